// File: rtl/i2s_serializer.sv
// I2S transmitter: oversamples the divider's bit clock on clock_in and shifts out
// stereo PCM pairs taken from a one-entry valid/ready holding buffer.
module i2s_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 16
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic                    bclk_in,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk_out,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LR_LO    = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] LR_HI    = CW'(FRAME_BITS - 2);
  localparam logic [CW-1:0] L_HI     = CW'(SAMPLE_WIDTH - 1);
  localparam logic [CW-1:0] R_LO     = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] R_HI     = CW'(SLOT_WIDTH + SAMPLE_WIDTH - 1);

  logic                    s1, s2, s3;
  logic                    fall_evt;
  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           n_next;
  logic [SAMPLE_WIDTH-1:0] left_sr, right_sr;
  logic [SAMPLE_WIDTH-1:0] hold_left, hold_right;
  logic                    hold_full;
  logic                    accept;
  logic                    frame_start;
  logic                    load;

  assign fall_evt     = s3 & ~s2;
  assign n_next       = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
  assign frame_start  = enable & fall_evt & (n_next == '0);
  assign load         = frame_start & hold_full;
  assign accept       = sample_valid & ~hold_full;
  assign sample_ready = ~hold_full;
  assign bclk_out     = s3;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A frame start drains the buffer; it can only load when full, so it never races an accept.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)    hold_full <= 1'b0;
    else if (load)   hold_full <= 1'b0;
    else if (accept) hold_full <= 1'b1;
  end

  // NOTE: data-only storage is left without reset; hold_full says whether it is meaningful.
  always_ff @(posedge clock_in) begin
    if (accept) begin
      hold_left  <= sample_left;
      hold_right <= sample_right;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= LAST_BIT;
      left_sr  <= '0;
      right_sr <= '0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (!enable) begin
        // Parking at the last bit makes the first fall after re-enable a frame start.
        bit_cnt  <= LAST_BIT;
        left_sr  <= '0;
        right_sr <= '0;
        lrclk    <= 1'b0;
        sdata    <= 1'b0;
      end else if (fall_evt) begin
        bit_cnt <= n_next;
        lrclk   <= (n_next >= LR_LO) && (n_next <= LR_HI);
        if (n_next == '0) begin
          if (hold_full) begin
            sdata    <= hold_left[SAMPLE_WIDTH-1];
            left_sr  <= hold_left << 1;
            right_sr <= hold_right;
          end else begin
            sdata    <= 1'b0;
            left_sr  <= '0;
            right_sr <= '0;
            underrun <= 1'b1;
          end
        end else if (n_next <= L_HI) begin
          sdata   <= left_sr[SAMPLE_WIDTH-1];
          left_sr <= left_sr << 1;
        end else if ((n_next >= R_LO) && (n_next <= R_HI)) begin
          sdata    <= right_sr[SAMPLE_WIDTH-1];
          right_sr <= right_sr << 1;
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: a 16/16 instance for framing, handshake,
// enable and reset behaviour, and a 24/32 instance for slot padding.
module tb_i2s_serializer;

  logic        clock_in, reset_n, bclk_in;
  logic        enable_a, enable_b;
  logic [15:0] left_a, right_a;
  logic [23:0] left_b, right_b;
  logic        valid_a, valid_b;
  logic        ready_a, bclk_out_a, lrclk_a, sdata_a, underrun_a;
  logic        ready_b, bclk_out_b, lrclk_b, sdata_b, underrun_b;

  int  n_vec  = 0;
  int  n_miss = 0;
  int  ur_cnt = 0, ur_run = 0, max_run = 0, ur_b = 0;
  time last_fall = 0;
  time dt_unused, dt2, dt3;

  i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16)) dut_a (
    .clock_in(clock_in), .reset_n(reset_n), .bclk_in(bclk_in), .enable(enable_a),
    .sample_left(left_a), .sample_right(right_a), .sample_valid(valid_a),
    .sample_ready(ready_a), .bclk_out(bclk_out_a), .lrclk(lrclk_a),
    .sdata(sdata_a), .underrun(underrun_a)
  );

  i2s_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32)) dut_b (
    .clock_in(clock_in), .reset_n(reset_n), .bclk_in(bclk_in), .enable(enable_b),
    .sample_left(left_b), .sample_right(right_b), .sample_valid(valid_b),
    .sample_ready(ready_b), .bclk_out(bclk_out_b), .lrclk(lrclk_b),
    .sdata(sdata_b), .underrun(underrun_b)
  );

  // clock_in period 10; bclk period 80 (8 clock_in cycles), edges kept off clock_in edges
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  initial begin
    bclk_in = 1'b0;
    #2;
    forever #40 bclk_in = ~bclk_in;
  end

  always @(negedge bclk_in) last_fall = $time;

  always @(negedge clock_in) begin
    if (underrun_a) begin
      if (ur_run == 0) ur_cnt++;
      ur_run++;
      if (ur_run > max_run) max_run = ur_run;
    end else begin
      ur_run = 0;
    end
    if (underrun_b) ur_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one pair, waits for ready, returns acceptance time minus the latest bclk_in fall.
  task automatic push_pair(input string tag, input bit sel, input logic [23:0] l,
                           input logic [23:0] r, output time acc_dt);
    int waited = 0;
    @(negedge clock_in);
    if (sel) begin left_b = l; right_b = r; valid_b = 1'b1; end
    else begin left_a = l[15:0]; right_a = r[15:0]; valid_a = 1'b1; end
    while (!(sel ? ready_b : ready_a) && waited < 2000) begin
      @(negedge clock_in);
      waited++;
    end
    check({tag, "_timeout"}, 64'(waited >= 2000), 64'd0);
    @(posedge clock_in);
    acc_dt = $time - last_fall;
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clock_in);
    check({tag, "_rdy_low"}, 64'(sel ? ready_b : ready_a), 64'd0);
  endtask

  // Samples nbits bit slots at bclk_in rising edges, MSB-first, and compares sdata/lrclk words.
  task automatic check_frame(input string tag, input bit sel, input int nbits,
                             input logic [63:0] exp_sd, input logic [63:0] exp_lr);
    logic [63:0] sd = '0;
    logic [63:0] lr = '0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge bclk_in);
      #1;
      sd = {sd[62:0], (sel ? sdata_b : sdata_a)};
      lr = {lr[62:0], (sel ? lrclk_b : lrclk_a)};
    end
    check({tag, "_sdata"}, sd, exp_sd);
    check({tag, "_lrclk"}, lr, exp_lr);
  endtask

  localparam logic [63:0] LR16 = 64'h0000_0000_0001_FFFE;
  localparam logic [63:0] LR32 = 64'h0000_0001_FFFF_FFFE;

  initial begin
    logic [63:0] sd6, lr6;
    reset_n  = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0;
    valid_a  = 1'b0; valid_b  = 1'b0;
    left_a = '0; right_a = '0; left_b = '0; right_b = '0;

    #1;
    check("rst_ready",    64'(ready_a),    64'd1);
    check("rst_bclk_out", 64'(bclk_out_a), 64'd0);
    check("rst_lrclk",    64'(lrclk_a),    64'd0);
    check("rst_sdata",    64'(sdata_a),    64'd0);
    check("rst_underrun", 64'(underrun_a), 64'd0);
    check("rst_ready_b",  64'(ready_b),    64'd1);
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;

    // T1: pair loaded while idle, then one full frame
    push_pair("t1_push", 1'b0, 24'hA5F0, 24'h0F0F, dt_unused);
    @(posedge bclk_in); #1;
    enable_a = 1'b1;
    check_frame("t1", 1'b0, 32, 64'hA5F0_0F0F, LR16);
    check("t1_no_underrun", 64'(ur_cnt), 64'd0);
    check("t1_ready_after", 64'(ready_a), 64'd1);

    // T2: empty buffer at frame start
    check_frame("t2", 1'b0, 32, 64'h0, LR16);
    check("t2_underrun_cnt", 64'(ur_cnt), 64'd1);

    // T3: three pairs back-to-back across three frames
    fork
      begin
        push_pair("t3_p1", 1'b0, 24'h1357, 24'h2468, dt_unused);
        push_pair("t3_p2", 1'b0, 24'h8421, 24'h7EE7, dt2);
        push_pair("t3_p3", 1'b0, 24'h0FF0, 24'hC001, dt3);
      end
      begin
        check_frame("t3_f1", 1'b0, 32, 64'h1357_2468, LR16);
        check_frame("t3_f2", 1'b0, 32, 64'h8421_7EE7, LR16);
        check_frame("t3_f3", 1'b0, 32, 64'h0FF0_C001, LR16);
      end
    join
    check("t3_p2_after_start", 64'(dt2 >= 23 && dt2 <= 33), 64'd1);
    check("t3_p3_after_start", 64'(dt3 >= 23 && dt3 <= 33), 64'd1);
    check("t3_no_underrun", 64'(ur_cnt), 64'd1);

    // T5: disable at n=5 with the next pair waiting in hold
    push_pair("t5_p4", 1'b0, 24'hFFFF, 24'h8001, dt_unused);
    sd6 = '0; lr6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge bclk_in); #1;
      sd6 = {sd6[62:0], sdata_a};
      lr6 = {lr6[62:0], lrclk_a};
    end
    check("t5_first6_sdata", sd6, 64'h3F);
    check("t5_first6_lrclk", lr6, 64'h0);
    push_pair("t5_p5", 1'b0, 24'hC3A5, 24'h5A3C, dt_unused);
    enable_a = 1'b0;
    @(negedge clock_in);
    check("t5_idle_sdata", 64'(sdata_a), 64'd0);
    check("t5_idle_lrclk", 64'(lrclk_a), 64'd0);
    check("t5_idle_ready", 64'(ready_a), 64'd0);
    repeat (3) @(posedge bclk_in);
    #1;
    check("t5_still_idle", 64'({sdata_a, lrclk_a, ready_a}), 64'd0);
    enable_a = 1'b1;
    check_frame("t5_resume", 1'b0, 32, 64'hC3A5_5A3C, LR16);
    check("t5_no_underrun", 64'(ur_cnt), 64'd1);

    // T6: asynchronous reset mid-frame, between clock_in edges
    fork
      begin
        push_pair("t6_p6", 1'b0, 24'h1234, 24'h5678, dt_unused);
        push_pair("t6_p7", 1'b0, 24'hDEAD, 24'hBEEF, dt_unused);
      end
      check_frame("t6_partial", 1'b0, 20, 64'h12345, 64'h1F);
    join
    #29;
    reset_n  = 1'b0;
    enable_a = 1'b0;
    #1;
    check("t6_bclk_out", 64'(bclk_out_a), 64'd0);
    check("t6_lrclk",    64'(lrclk_a),    64'd0);
    check("t6_sdata",    64'(sdata_a),    64'd0);
    check("t6_underrun", 64'(underrun_a), 64'd0);
    check("t6_ready",    64'(ready_a),    64'd1);
    #50;
    reset_n = 1'b1;
    push_pair("t6_rec_push", 1'b0, 24'hA5F0, 24'h0F0F, dt_unused);
    repeat (2) @(posedge bclk_in);
    #1;
    enable_a = 1'b1;
    check_frame("t6_recover", 1'b0, 32, 64'hA5F0_0F0F, LR16);
    enable_a = 1'b0;
    check("t6_underrun_cnt", 64'(ur_cnt), 64'd1);

    // T4: 24-bit samples in 32-bit slots
    push_pair("t4_push", 1'b1, 24'h800001, 24'h123456, dt_unused);
    @(posedge bclk_in); #1;
    enable_b = 1'b1;
    check_frame("t4", 1'b1, 64, 64'h8000_0100_1234_5600, LR32);
    enable_b = 1'b0;
    check("t4_no_underrun", 64'(ur_b), 64'd0);

    check("underrun_width", 64'(max_run), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
